// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and helpers for the divide-tick scheduler.
//   state_e   : controller state encoding
//   DIV*      : divide-select codes (period 2,4,8,16)
//   div_tc()  : divide select -> terminal prescaler value (period - 1)
package div_sched_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  localparam logic [1:0] DIV2  = 2'd0;
  localparam logic [1:0] DIV4  = 2'd1;
  localparam logic [1:0] DIV8  = 2'd2;
  localparam logic [1:0] DIV16 = 2'd3;

  function automatic logic [3:0] div_tc(input logic [1:0] sel);
    case (sel)
      DIV2:    return 4'd1;
      DIV4:    return 4'd3;
      DIV8:    return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/div_prescaler.sv
// div_prescaler: 4-bit prescaler for the shared tick generator.
//   clk_i, rst_i : clock, async active-high reset
//   clr_i        : synchronous clear (wins over enable)
//   en_i         : count enable
//   sel_i        : divide select (DIV2..DIV16)
//   tc_o         : count is at terminal value for sel_i
module div_prescaler
  import div_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] sel_i,
  output logic       tc_o
);

  logic [3:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == div_tc(sel_i));

  // Wrap at terminal count so the period is exactly div_tc+1 cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? 4'd0 : cnt_q + 4'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/div_scheduler.sv
// div_scheduler: round-robin share of one divide-by-2/4/8/16 tick generator
// between requesters A and B. The winner's divide select and tick count are
// latched at grant; the job emits exactly Count ticks, then pulses Done.
//   clk_i, rst_i               : clock, async active-high reset
//   req_{a,b}_i                : request, held until done (drop = abort)
//   div_{a,b}_i                : divide select, sampled at grant only
//   count_{a,b}_i              : ticks wanted, sampled at grant only
//   gnt_{a,b}_o                : grant, high from LOAD through DONE
//   busy_o                     : controller not idle
//   tick_o                     : one pulse per divided period
//   done_{a,b}_o               : one-cycle completion pulse
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_a_i,
  input  logic [1:0]       div_a_i,
  input  logic [CNT_W-1:0] count_a_i,
  input  logic             req_b_i,
  input  logic [1:0]       div_b_i,
  input  logic [CNT_W-1:0] count_b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_a_o,
  output logic             done_b_o
);

  state_e           state_q, state_d;
  logic             own_b_q, own_b_d;   // current owner: 0 = A, 1 = B
  logic             ptr_b_q, ptr_b_d;   // tie-break priority: 0 = A, 1 = B
  logic [1:0]       sel_q, sel_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             own_req, win_b, pre_clr, pre_en, pre_tc;

  assign own_req = own_b_q ? req_b_i : req_a_i;

  always_comb begin
    state_d = state_q;
    own_b_d = own_b_q;
    ptr_b_d = ptr_b_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    win_b   = 1'b0;
    pre_clr = 1'b0;
    pre_en  = 1'b0;
    case (state_q)
      IDLE: begin
        pre_clr = 1'b1;
        if (req_a_i || req_b_i) begin
          win_b   = req_b_i && (!req_a_i || ptr_b_q);
          own_b_d = win_b;
          ptr_b_d = !win_b;
          sel_d   = win_b ? div_b_i : div_a_i;
          // remaining is loaded straight from the winner; LOAD only has to
          // screen out empty jobs.
          rem_d   = win_b ? count_b_i : count_a_i;
          state_d = LOAD;
        end
      end
      LOAD: begin
        pre_clr = 1'b1;
        if (!own_req)         state_d = IDLE;
        else if (rem_q == '0) state_d = DONE;
        else                  state_d = RUN;
      end
      RUN: begin
        pre_en = 1'b1;
        if (!own_req) state_d = IDLE;
        else if (pre_tc) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      own_b_q <= 1'b0;
      ptr_b_q <= 1'b0;
      sel_q   <= DIV2;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      own_b_q <= own_b_d;
      ptr_b_q <= ptr_b_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
    end
  end

  div_prescaler u_pre (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (pre_clr),
    .en_i  (pre_en),
    .sel_i (sel_q),
    .tc_o  (pre_tc)
  );

  // Everything below is decoded from registered state only.
  assign busy_o   = (state_q != IDLE);
  assign gnt_a_o  = busy_o && !own_b_q;
  assign gnt_b_o  = busy_o &&  own_b_q;
  assign tick_o   = (state_q == RUN) && pre_tc;
  assign done_a_o = (state_q == DONE) && !own_b_q;
  assign done_b_o = (state_q == DONE) &&  own_b_q;

endmodule

// File: tb/tb_div_scheduler.sv
module tb_div_scheduler;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_a, req_b;
  logic [1:0]       div_a, div_b;
  logic [CNT_W-1:0] count_a, count_b;
  logic             gnt_a, gnt_b, busy, tick, done_a, done_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_scheduler #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_a_i(req_a), .div_a_i(div_a), .count_a_i(count_a),
    .req_b_i(req_b), .div_b_i(div_b), .count_b_i(count_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .busy_o(busy), .tick_o(tick),
    .done_a_o(done_a), .done_b_o(done_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output bundle order: {gnt_a, gnt_b, busy, tick, done_a, done_b}
  task automatic outs(input string name, input logic [5:0] exp);
    chk(name, int'({gnt_a, gnt_b, busy, tick, done_a, done_b}), int'(exp));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);
    outs("reset_outs", 6'b000000);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         side_b;
    logic [1:0] div;
    int         cnt;
    int         first_tick;
    int         n_ticks;
    int         period;
    int         done_cyc;
  } vec_t;

  // Cycle k is the clock period following edge k; the grant edge is edge 0.
  task automatic run_vec(input vec_t v, input int idx);
    int   done_at, ticks, first, last, bad_gap, gnt_cyc, other;
    logic g_own, d_own, g_oth, d_oth;
    done_at = -1; ticks = 0; first = -1; last = -1;
    bad_gap = 0; gnt_cyc = 0; other = 0;
    if (v.side_b) begin req_b = 1'b1; div_b = v.div; count_b = CNT_W'(v.cnt); end
    else          begin req_a = 1'b1; div_a = v.div; count_a = CNT_W'(v.cnt); end
    for (int cyc = 1; cyc <= 5000 && done_at < 0; cyc++) begin
      @(negedge clk);
      // Change the inputs mid-job; they must have no effect.
      if (cyc == 1) begin
        if (v.side_b) begin div_b = ~v.div; count_b = CNT_W'(v.cnt) ^ 8'h5A; end
        else          begin div_a = ~v.div; count_a = CNT_W'(v.cnt) ^ 8'h5A; end
      end
      g_own = v.side_b ? gnt_b  : gnt_a;
      d_own = v.side_b ? done_b : done_a;
      g_oth = v.side_b ? gnt_a  : gnt_b;
      d_oth = v.side_b ? done_a : done_b;
      if (g_own) gnt_cyc++;
      if (g_oth || d_oth) other++;
      if (tick) begin
        ticks++;
        if (first < 0) first = cyc;
        else if (cyc - last != v.period) bad_gap++;
        last = cyc;
      end
      if (d_own) begin
        done_at = cyc;
        req_a = 1'b0; req_b = 1'b0;
      end
    end
    chk($sformatf("v%0d done_cycle", idx), done_at, v.done_cyc);
    chk($sformatf("v%0d tick_count", idx), ticks, v.n_ticks);
    chk($sformatf("v%0d first_tick", idx), first, v.first_tick);
    chk($sformatf("v%0d tick_gap_errors", idx), bad_gap, 0);
    chk($sformatf("v%0d gnt_cycles", idx), gnt_cyc, v.done_cyc);
    chk($sformatf("v%0d other_side_activity", idx), other, 0);
    @(negedge clk);
    outs($sformatf("v%0d idle_after_done", idx), 6'b000000);
  endtask

  vec_t tv[8];

  initial begin
    tv[0] = '{1'b0, 2'd0,   3,  3,   3,  2,    8};
    tv[1] = '{1'b1, 2'd3,   2, 17,   2, 16,   34};
    tv[2] = '{1'b0, 2'd0,   0, -1,   0,  2,    2};
    tv[3] = '{1'b1, 2'd1,   1,  5,   1,  4,    6};
    tv[4] = '{1'b0, 2'd2,   5,  9,   5,  8,   42};
    tv[5] = '{1'b0, 2'd3, 255, 17, 255, 16, 4082};
    tv[6] = '{1'b1, 2'd0,   1,  3,   1,  2,    4};
    tv[7] = '{1'b1, 2'd2,   0, -1,   0,  8,    2};

    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0;
    div_a = 2'd0; div_b = 2'd0; count_a = '0; count_b = '0;
    repeat (2) @(negedge clk);
    outs("reset_outs_initial", 6'b000000);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(tv[i], i);

    // Both requesting from reset: A, then B, then A again; held requests alternate.
    do_reset();
    div_a = 2'd0; count_a = '0; div_b = 2'd0; count_b = '0;
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clk); outs("both_c1_gntA",  6'b101000);
    @(negedge clk); outs("both_c2_doneA", 6'b101010);
    @(negedge clk); outs("both_c3_idle",  6'b000000);
    @(negedge clk); outs("both_c4_gntB",  6'b011000);
    @(negedge clk); outs("both_c5_doneB", 6'b011001);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); outs("both_c6_idle",  6'b000000);
    req_a = 1'b1; req_b = 1'b1;
    @(negedge clk); outs("rerise_gntA",   6'b101000);
    @(negedge clk); outs("rerise_doneA",  6'b101010);
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); outs($sformatf("alt%0d_idle1", r),  6'b000000);
      @(negedge clk); outs($sformatf("alt%0d_gntB", r),   6'b011000);
      @(negedge clk); outs($sformatf("alt%0d_doneB", r),  6'b011001);
      @(negedge clk); outs($sformatf("alt%0d_idle2", r),  6'b000000);
      @(negedge clk); outs($sformatf("alt%0d_gntA", r),   6'b101000);
      @(negedge clk); outs($sformatf("alt%0d_doneA", r),  6'b101010);
    end
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk);

    // Abort: A (div4, 4 ticks) drops after its first tick; pending B follows.
    do_reset();
    div_a = 2'd1; count_a = 8'd4; req_a = 1'b1;
    @(negedge clk); outs("abort_c1_gntA", 6'b101000);
    req_b = 1'b1; div_b = 2'd0; count_b = 8'd1;
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk); outs($sformatf("abort_c%0d_run", c), 6'b101000);
    end
    @(negedge clk); outs("abort_c5_tick", 6'b101100);
    @(negedge clk); outs("abort_c6_run",  6'b101000);
    req_a = 1'b0;
    @(negedge clk); outs("abort_c7_idle", 6'b000000);
    @(negedge clk); outs("abort_c8_gntB", 6'b011000);
    @(negedge clk); outs("abort_c9_runB", 6'b011000);
    @(negedge clk); outs("abort_c10_tickB", 6'b011100);
    @(negedge clk); outs("abort_c11_doneB", 6'b011001);
    req_b = 1'b0;
    @(negedge clk); outs("abort_c12_idle", 6'b000000);

    // Reset mid-RUN clears outputs at once and restores A priority.
    do_reset();
    div_a = 2'd2; count_a = 8'd3; req_a = 1'b1;
    @(negedge clk); outs("rst_c1_gntA", 6'b101000);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk); outs($sformatf("rst_c%0d_run", c), 6'b101000);
    end
    rst = 1'b1;
    #1 outs("rst_async_clear", 6'b000000);
    @(negedge clk); outs("rst_held", 6'b000000);
    rst = 1'b0;
    div_a = 2'd0; count_a = 8'd1; req_b = 1'b1; div_b = 2'd0; count_b = 8'd1;
    @(negedge clk); outs("post_rst_gntA", 6'b101000);
    @(negedge clk); outs("post_rst_run",  6'b101000);
    @(negedge clk); outs("post_rst_tick", 6'b101100);
    @(negedge clk); outs("post_rst_done", 6'b101010);
    req_a = 1'b0; req_b = 1'b0;
    @(negedge clk); outs("post_rst_idle", 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
